phy_link_sched: RTL and testbench

Transmit-side link controller and lane scheduler for the PHY. Trains the serial link by sending comma symbols until the receiver reports lock. Then shares the single byte-wide serializer input among the four lane requesters with a round-robin arbiter, and inserts idle symbols when no lane has data. It sits between the four lane sources and the TX serializer, and takes its lock status from the RX alignment logic.

---
 rtl/phy_link_pkg.sv | 15 +
 rtl/rr_arbiter4.sv | 31 +++
 rtl/phy_link_sched.sv | 158 +++++++++++++++
 tb/tb_phy_link_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/phy_link_pkg.sv
// Shared definitions for the PHY transmit link scheduler: state encoding,
// default symbols and lane count.
package phy_link_pkg;

    typedef enum logic [1:0] {
        ST_RESET  = 2'b00,
        ST_TRAIN  = 2'b01,
        ST_ACTIVE = 2'b10
    } link_state_t;

    localparam logic [7:0] COMMA_DEFAULT = 8'hBC;
    localparam logic [7:0] IDLE_DEFAULT  = 8'h7C;
    localparam int         NUM_LANES     = 4;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter: grants the first requester found after the
// pointer position, wrapping around.
module rr_arbiter4
    import phy_link_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [3:0] grant,
    output logic [1:0] index,
    output logic       any_grant
);

    logic [1:0] cand;

    // The last candidate (k = 4) wraps back to the pointer lane itself.
    always_comb begin
        grant     = '0;
        index     = ptr;
        any_grant = 1'b0;
        cand      = ptr;
        for (int k = 1; k <= NUM_LANES; k++) begin
            cand = ptr + 2'(k);
            if (!any_grant && req[cand]) begin
                grant[cand] = 1'b1;
                index       = cand;
                any_grant   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/phy_link_sched.sv
// Transmit link controller: trains the link with commas until RX lock, then
// round-robin schedules four lane holding registers onto the serializer.
module phy_link_sched
    import phy_link_pkg::*;
#(
    parameter int         SYNC_CYCLES = 4,
    parameter int         LOSS_CYCLES = 8,
    parameter logic [7:0] COMMA       = COMMA_DEFAULT,
    parameter logic [7:0] IDLE_SYM    = IDLE_DEFAULT
) (
    input  logic       clk_f,
    input  logic       reset,
    input  logic [7:0] data_in_0,
    input  logic [7:0] data_in_1,
    input  logic [7:0] data_in_2,
    input  logic [7:0] data_in_3,
    input  logic       valid_in_0,
    input  logic       valid_in_1,
    input  logic       valid_in_2,
    input  logic       valid_in_3,
    output logic       ready_0,
    output logic       ready_1,
    output logic       ready_2,
    output logic       ready_3,
    input  logic       rx_sync,
    output logic [7:0] tx_data,
    output logic       tx_k,
    output logic       tx_valid,
    output logic [1:0] tx_lane,
    output logic       link_up,
    output logic [1:0] state
);

    localparam int SYNC_W = $clog2(SYNC_CYCLES + 1);
    localparam int LOSS_W = $clog2(LOSS_CYCLES + 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_CYCLES - 1);
    localparam logic [SYNC_W-1:0] SYNC_MAX  = SYNC_W'(SYNC_CYCLES);
    localparam logic [LOSS_W-1:0] LOSS_LAST = LOSS_W'(LOSS_CYCLES - 1);

    link_state_t       state_q;
    logic [SYNC_W-1:0] sync_cnt;
    logic [LOSS_W-1:0] loss_cnt;
    logic [1:0]        ptr;
    logic [3:0]        full;
    logic [7:0]        hold [NUM_LANES];
    logic [7:0]        din  [NUM_LANES];
    logic [3:0]        vin;
    logic [3:0]        grant;
    logic [3:0]        grant_en;
    logic [1:0]        grant_idx;
    logic              any_grant;

    assign din[0] = data_in_0;
    assign din[1] = data_in_1;
    assign din[2] = data_in_2;
    assign din[3] = data_in_3;
    assign vin    = {valid_in_3, valid_in_2, valid_in_1, valid_in_0};

    assign ready_0 = ~full[0];
    assign ready_1 = ~full[1];
    assign ready_2 = ~full[2];
    assign ready_3 = ~full[3];

    assign state    = state_q;
    assign grant_en = (state_q == ST_ACTIVE) ? grant : 4'b0000;

    rr_arbiter4 u_arb (
        .req       (full),
        .ptr       (ptr),
        .grant     (grant),
        .index     (grant_idx),
        .any_grant (any_grant)
    );

    // A full register cannot accept, so grant and accept never collide on one lane.
    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            full <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                hold[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (grant_en[i]) begin
                    full[i] <= 1'b0;
                end else if (vin[i] && !full[i]) begin
                    full[i] <= 1'b1;
                    hold[i] <= din[i];
                end
            end
        end
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RESET;
            sync_cnt <= '0;
            loss_cnt <= '0;
            ptr      <= 2'd3;
            tx_data  <= IDLE_SYM;
            tx_k     <= 1'b1;
            tx_valid <= 1'b0;
            tx_lane  <= 2'd0;
            link_up  <= 1'b0;
        end else begin
            case (state_q)
                ST_RESET: begin
                    state_q <= ST_TRAIN;
                end
                ST_TRAIN: begin
                    tx_data  <= COMMA;
                    tx_k     <= 1'b1;
                    tx_valid <= 1'b0;
                    loss_cnt <= '0;
                    if (rx_sync) begin
                        if (sync_cnt == SYNC_LAST) begin
                            state_q <= ST_ACTIVE;
                            link_up <= 1'b1;
                        end
                        if (sync_cnt != SYNC_MAX) begin
                            sync_cnt <= sync_cnt + 1'b1;
                        end
                    end else begin
                        sync_cnt <= '0;
                    end
                end
                ST_ACTIVE: begin
                    if (any_grant) begin
                        tx_data  <= hold[grant_idx];
                        tx_k     <= 1'b0;
                        tx_valid <= 1'b1;
                        tx_lane  <= grant_idx;
                        ptr      <= grant_idx;
                    end else begin
                        tx_data  <= IDLE_SYM;
                        tx_k     <= 1'b1;
                        tx_valid <= 1'b0;
                    end
                    // Retrain on a sustained run of lost sync; buffered bytes wait.
                    if (rx_sync) begin
                        loss_cnt <= '0;
                    end else if (loss_cnt == LOSS_LAST) begin
                        state_q  <= ST_TRAIN;
                        link_up  <= 1'b0;
                        sync_cnt <= '0;
                        loss_cnt <= '0;
                    end else begin
                        loss_cnt <= loss_cnt + 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_RESET;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_phy_link_sched.sv
// Self-checking bench for phy_link_sched: table-driven training vectors,
// hand-written traffic sequences and a scoreboard on the serializer output.
module tb_phy_link_sched;

    typedef struct packed {
        logic       do_reset;
        logic       rx;
        logic [1:0] exp_state;
        logic       exp_link;
        logic [7:0] exp_data;
        logic       exp_k;
    } vec_t;

    typedef struct packed {
        logic [1:0] lane;
        logic [7:0] data;
    } exp_t;

    logic       clk_f = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] din [4];
    logic [3:0] vin;
    logic       rx_sync;
    wire  [3:0] rdy;
    wire  [7:0] tx_data;
    wire        tx_k;
    wire        tx_valid;
    wire  [1:0] tx_lane;
    wire        link_up;
    wire  [1:0] state;

    vec_t vecs [16];
    exp_t sb [$];
    exp_t mon_e;
    int   tests_run    = 0;
    int   tests_failed = 0;

    always #5 clk_f = ~clk_f;

    phy_link_sched dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .data_in_0  (din[0]),
        .data_in_1  (din[1]),
        .data_in_2  (din[2]),
        .data_in_3  (din[3]),
        .valid_in_0 (vin[0]),
        .valid_in_1 (vin[1]),
        .valid_in_2 (vin[2]),
        .valid_in_3 (vin[3]),
        .ready_0    (rdy[0]),
        .ready_1    (rdy[1]),
        .ready_2    (rdy[2]),
        .ready_3    (rdy[3]),
        .rx_sync    (rx_sync),
        .tx_data    (tx_data),
        .tx_k       (tx_k),
        .tx_valid   (tx_valid),
        .tx_lane    (tx_lane),
        .link_up    (link_up),
        .state      (state)
    );

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_f);
        #1;
    endtask

    // Asserts reset between edges so the checks see the asynchronous effect.
    task automatic pulse_reset();
        reset = 1'b1;
        vin   = 4'b0000;
        #1;
        check_output("rst tx_data", 32'(tx_data), 32'h7C);
        check_output("rst tx_k", 32'(tx_k), 32'd1);
        check_output("rst tx_valid", 32'(tx_valid), 32'd0);
        check_output("rst tx_lane", 32'(tx_lane), 32'd0);
        check_output("rst link_up", 32'(link_up), 32'd0);
        check_output("rst state", 32'(state), 32'd0);
        check_output("rst ready", 32'(rdy), 32'hF);
        sb.delete();
        tick();
        tick();
        reset = 1'b0;
        #1;
        check_output("post-rst state", 32'(state), 32'd0);
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        if (v.do_reset) pulse_reset();
        rx_sync = v.rx;
        tick();
        check_output($sformatf("vec%0d state", idx), 32'(state), 32'(v.exp_state));
        check_output($sformatf("vec%0d link_up", idx), 32'(link_up), 32'(v.exp_link));
        check_output($sformatf("vec%0d tx_data", idx), 32'(tx_data), 32'(v.exp_data));
        check_output($sformatf("vec%0d tx_k", idx), 32'(tx_k), 32'(v.exp_k));
        check_output($sformatf("vec%0d tx_valid", idx), 32'(tx_valid), 32'd0);
    endtask

    // Every lane byte leaving the serializer must match the oldest expectation.
    always @(negedge clk_f) begin
        if (tx_valid === 1'b1) begin
            if (sb.size() == 0) begin
                tests_run++;
                tests_failed++;
                $display("[TB] FAIL unexpected byte: got %0h on lane %0d, expected none",
                         tx_data, tx_lane);
            end else begin
                mon_e = sb.pop_front();
                check_output("sb data", 32'(tx_data), 32'(mon_e.data));
                check_output("sb lane", 32'(tx_lane), 32'(mon_e.lane));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        logic       exp_rdy;

        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        vin     = 4'b0000;
        rx_sync = 1'b1;

        // Clean lock, then a lock attempt interrupted after three samples.
        vecs[0]  = '{1'b1, 1'b1, 2'b01, 1'b0, 8'h7C, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[2]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 2'b10, 1'b1, 8'hBC, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h7C, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 2'b01, 1'b0, 8'h7C, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 1'b0, 8'hBC, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'hBC, 1'b1};
        vecs[15] = '{1'b0, 1'b1, 2'b10, 1'b1, 8'h7C, 1'b1};

        tick();
        for (int i = 0; i < 16; i++) apply_stimulus(vecs[i], i);

        // All four lanes loaded at once; pointer starts at 3 so lane 0 goes first.
        din[0] = 8'h10; din[1] = 8'h21; din[2] = 8'h32; din[3] = 8'h43;
        vin = 4'b1111;
        for (int i = 0; i < 4; i++) sb.push_back('{2'(i), din[i]});
        tick();
        vin = 4'b0000;
        check_output("all-load ready", 32'(rdy), 32'h0);
        for (int i = 0; i < 4; i++) tick();
        check_output("all-load last lane", 32'(tx_lane), 32'd3);
        check_output("all-load last data", 32'(tx_data), 32'h43);
        tick();
        check_output("all-load idle data", 32'(tx_data), 32'h7C);
        check_output("all-load idle k", 32'(tx_k), 32'd1);
        check_output("all-load idle valid", 32'(tx_valid), 32'd0);
        check_output("all-load lane held", 32'(tx_lane), 32'd3);
        check_output("all-load ready back", 32'(rdy), 32'hF);

        // Lane 2 streams with valid held high; it alternates accept and grant.
        b = 8'hA0;
        exp_rdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            vin[2] = 1'b1;
            din[2] = b;
            check_output($sformatf("stream ready c%0d", c), 32'(rdy[2]), 32'(exp_rdy));
            if (exp_rdy) sb.push_back('{2'd2, b});
            tick();
            if (exp_rdy) b = b + 8'd1;
            check_output($sformatf("stream valid c%0d", c), 32'(tx_valid), 32'(c % 2));
            exp_rdy = !exp_rdy;
        end
        vin[2] = 1'b0;
        tick();
        tick();
        check_output("stream drained", 32'(sb.size()), 32'd0);

        // Loss of sync for eight samples forces retraining; lane 1 waits it out.
        rx_sync = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check_output("loss k7 state", 32'(state), 32'd2);
        end
        check_output("loss state", 32'(state), 32'd1);
        check_output("loss link_up", 32'(link_up), 32'd0);
        vin[1] = 1'b1;
        din[1] = 8'h55;
        sb.push_back('{2'd1, 8'h55});
        tick();
        vin[1] = 1'b0;
        check_output("retrain comma", 32'(tx_data), 32'hBC);
        check_output("retrain k", 32'(tx_k), 32'd1);
        check_output("retrain ready1", 32'(rdy[1]), 32'd0);
        rx_sync = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        check_output("relock state", 32'(state), 32'd2);
        check_output("relock link_up", 32'(link_up), 32'd1);
        tick();
        check_output("relock first valid", 32'(tx_valid), 32'd1);
        check_output("relock first lane", 32'(tx_lane), 32'd1);
        check_output("relock first data", 32'(tx_data), 32'h55);
        tick();

        // Fill every lane, then reset before any can be granted.
        for (int i = 0; i < 4; i++) din[i] = 8'hE0 + 8'(i);
        vin = 4'b1111;
        tick();
        vin = 4'b0000;
        #1;
        check_output("pre-reset ready", 32'(rdy), 32'h0);
        pulse_reset();
        rx_sync = 1'b1;
        for (int k = 0; k < 9; k++) tick();
        check_output("after-reset state", 32'(state), 32'd2);
        check_output("after-reset valid", 32'(tx_valid), 32'd0);
        check_output("after-reset ready", 32'(rdy), 32'hF);
        check_output("final scoreboard", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
